// File: rtl/mode_timer.sv
// Programmable modulo timer with periodic/one-shot modes, start/stop control and runtime modulus.
// Optional increment prescaler is enabled by defining TIMER_PRESCALE_EN.
module mode_timer #(
  parameter int unsigned BIT_WIDTH   = 16,
  parameter int unsigned MOD_DEFAULT = 1000,
  parameter int unsigned PRESCALE    = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 increment,
  input  logic                 start,
  input  logic                 stop,
  input  logic                 mode,
  input  logic                 cfg_wr,
  input  logic [BIT_WIDTH-1:0] cfg_mod,
  output logic [BIT_WIDTH-1:0] count,
  output logic                 rolling_over,
  output logic                 running,
  output logic                 done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state, state_next;
  logic [BIT_WIDTH-1:0] count_next;
  logic [BIT_WIDTH-1:0] modulus;
  logic [BIT_WIDTH-1:0] terminal;
  logic                 mode_q, mode_next;
  logic                 advance;
  logic                 pre_tick;
  logic                 launch;

  if (PRESCALE < 1) begin : g_bad_prescale
    $error("mode_timer: PRESCALE must be >= 1");
  end

`ifdef TIMER_PRESCALE_EN
  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PW-1:0] pre, pre_next;

  assign pre_tick = (pre == PW'(PRESCALE - 1));

  always_comb begin
    pre_next = pre;
    if (stop) begin
      pre_next = pre;
    end else if (launch) begin
      pre_next = '0;
    end else if (state == RUN && increment) begin
      pre_next = pre_tick ? '0 : pre + PW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) pre <= '0;
    else       pre <= pre_next;
  end
`else
  assign pre_tick = 1'b1;
`endif

  // modulus 0 wraps to all-ones, giving a full 2^BIT_WIDTH period
  assign terminal     = modulus - BIT_WIDTH'(1);
  assign launch       = start && (state != RUN);
  assign advance      = (state == RUN) && increment && !stop && pre_tick;
  assign rolling_over = advance && (count == terminal);

  always_comb begin
    state_next = state;
    count_next = count;
    mode_next  = mode_q;
    if (stop) begin
      state_next = IDLE;
    end else if (launch) begin
      state_next = RUN;
      count_next = '0;
      mode_next  = mode;
    end else if (advance) begin
      if (count == terminal) begin
        count_next = '0;
        if (mode_q) state_next = DONE;
      end else begin
        count_next = count + BIT_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      count   <= '0;
      modulus <= BIT_WIDTH'(MOD_DEFAULT);
      mode_q  <= 1'b0;
      running <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_next;
      count   <= count_next;
      mode_q  <= mode_next;
      running <= (state_next == RUN);
      done    <= (state_next == DONE);
      if (cfg_wr && state != RUN) modulus <= cfg_mod;
    end
  end

endmodule

// File: tb/tb_mode_timer.sv
// Scoreboard bench for mode_timer: a 16-bit instance and a 4-bit instance share stimulus;
// each vector pushes the expected outputs for its cycle and a monitor checks them mid-cycle.
module tb_mode_timer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        increment = 1'b0, start = 1'b0, stop = 1'b0, mode = 1'b0, cfg_wr = 1'b0;
  logic [15:0] cfg_mod = '0;

  logic [15:0] count16;
  logic        ro16, run16, done16;
  logic [3:0]  count4;
  logic        ro4, run4, done4;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [15:0] c;
    logic        ro;
    logic        rn;
    logic        dn;
    int          sel;
    string       name;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  mode_timer #(.BIT_WIDTH(16), .MOD_DEFAULT(1000), .PRESCALE(4)) u16 (
    .clk(clk), .reset(reset), .increment(increment), .start(start), .stop(stop),
    .mode(mode), .cfg_wr(cfg_wr), .cfg_mod(cfg_mod),
    .count(count16), .rolling_over(ro16), .running(run16), .done(done16)
  );

  mode_timer #(.BIT_WIDTH(4), .MOD_DEFAULT(0), .PRESCALE(4)) u4 (
    .clk(clk), .reset(reset), .increment(increment), .start(start), .stop(stop),
    .mode(mode), .cfg_wr(cfg_wr), .cfg_mod(cfg_mod[3:0]),
    .count(count4), .rolling_over(ro4), .running(run4), .done(done4)
  );

  // Monitor: outputs are checked at the falling edge of the cycle the vector was applied in.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t        e;
      logic [15:0] ac;
      logic        aro, arn, adn;
      e = sb.pop_front();
      if (e.sel == 1) begin
        ac = {12'b0, count4}; aro = ro4; arn = run4; adn = done4;
      end else begin
        ac = count16; aro = ro16; arn = run16; adn = done16;
      end
      checks++;
      if (ac !== e.c || aro !== e.ro || arn !== e.rn || adn !== e.dn) begin
        failures++;
        $display("FAIL %s: got count=%0d ro=%b run=%b done=%b, want count=%0d ro=%b run=%b done=%b",
                 e.name, ac, aro, arn, adn, e.c, e.ro, e.rn, e.dn);
      end
    end
  end

  task automatic vec(input logic rst, input logic inc, input logic st, input logic sp,
                     input logic md, input logic wr, input logic [15:0] cm,
                     input logic [15:0] ec, input logic ero, input logic ern, input logic edn,
                     input int sel, input string name);
    exp_t e;
    @(posedge clk);
    #1;
    reset = rst; increment = inc; start = st; stop = sp; mode = md; cfg_wr = wr; cfg_mod = cm;
    e.c = ec; e.ro = ero; e.rn = ern; e.dn = edn; e.sel = sel; e.name = name;
    sb.push_back(e);
  endtask

  task automatic do_reset(input int sel);
    vec(1, 0, 0, 0, 0, 0, 16'd0, 16'd0, 0, 0, 0, sel, "reset_asserted");
    vec(0, 0, 0, 0, 0, 0, 16'd0, 16'd0, 0, 0, 0, sel, "reset_released");
  endtask

  initial begin
    repeat (2) @(posedge clk);
    do_reset(0);

`ifdef TIMER_PRESCALE_EN
    // modulus 2, prescale 4: count steps every 4th increment, rollover on #8 and #16
    vec(0, 1, 1, 0, 0, 1, 16'd2, 16'd0, 0, 0, 0, 0, "pre_start");
    for (int n = 1; n <= 16; n++)
      vec(0, 1, 0, 0, 0, 0, 16'd0, 16'(((n - 1) / 4) % 2), (n % 8) == 0, 1, 0, 0, "pre_tick");
    vec(0, 0, 0, 0, 0, 0, 16'd0, 16'd0, 0, 1, 0, 0, "pre_after");
`else
    // default modulus 1000 via periodic run
    vec(0, 1, 1, 0, 0, 0, 16'd0, 16'd0, 0, 0, 0, 0, "def_start");
    for (int k = 0; k < 1000; k++)
      vec(0, 1, 0, 0, 0, 0, 16'd0, 16'(k), k == 999, 1, 0, 0, "def_run");
    vec(0, 0, 0, 1, 0, 0, 16'd0, 16'd0, 0, 1, 0, 0, "def_stop");

    // reset mid-run at count 37 clears outputs before the next edge
    vec(0, 0, 1, 0, 0, 0, 16'd0, 16'd0, 0, 0, 0, 0, "r37_start");
    for (int k = 0; k < 37; k++)
      vec(0, 1, 0, 0, 0, 0, 16'd0, 16'(k), 0, 1, 0, 0, "r37_run");
    do_reset(0);

    // periodic modulus 5, 12 increments
    vec(0, 1, 1, 0, 0, 1, 16'd5, 16'd0, 0, 0, 0, 0, "per_start");
    for (int k = 0; k < 12; k++)
      vec(0, 1, 0, 0, 0, 0, 16'd0, 16'(k % 5), (k % 5) == 4, 1, 0, 0, "per_run");
    vec(0, 1, 0, 0, 0, 1, 16'd9, 16'd2, 0, 1, 0, 0, "cfg_in_run");
    vec(0, 1, 0, 0, 0, 0, 16'd0, 16'd3, 0, 1, 0, 0, "per_to4");
    vec(0, 1, 0, 1, 0, 0, 16'd0, 16'd4, 0, 1, 0, 0, "stop_at_term");
    vec(0, 0, 0, 0, 0, 0, 16'd0, 16'd4, 0, 0, 0, 0, "paused_idle");
    vec(0, 1, 1, 0, 0, 0, 16'd0, 16'd4, 0, 0, 0, 0, "restart");
    for (int k = 0; k < 5; k++)
      vec(0, 1, 0, 0, 0, 0, 16'd0, 16'(k), k == 4, 1, 0, 0, "mod_still5");
    vec(0, 0, 0, 1, 0, 0, 16'd0, 16'd0, 0, 1, 0, 0, "per_stop");

    // one-shot modulus 3
    vec(0, 1, 1, 0, 1, 1, 16'd3, 16'd0, 0, 0, 0, 0, "os_start");
    vec(0, 1, 0, 0, 0, 0, 16'd0, 16'd0, 0, 1, 0, 0, "os_t1");
    vec(0, 1, 1, 0, 0, 0, 16'd0, 16'd1, 0, 1, 0, 0, "os_t2_start_ignored");
    vec(0, 1, 0, 0, 0, 0, 16'd0, 16'd2, 1, 1, 0, 0, "os_t3");
    vec(0, 1, 0, 0, 0, 0, 16'd0, 16'd0, 0, 0, 1, 0, "os_done");
    vec(0, 1, 0, 0, 0, 0, 16'd0, 16'd0, 0, 0, 1, 0, "os_done_hold");

    // periodic modulus 1: rolling_over follows increment
    vec(0, 0, 1, 0, 0, 1, 16'd1, 16'd0, 0, 0, 1, 0, "m1_start");
    vec(0, 1, 0, 0, 0, 0, 16'd0, 16'd0, 1, 1, 0, 0, "m1_a");
    vec(0, 0, 0, 0, 0, 0, 16'd0, 16'd0, 0, 1, 0, 0, "m1_b");
    vec(0, 1, 0, 0, 0, 0, 16'd0, 16'd0, 1, 1, 0, 0, "m1_c");
    vec(0, 1, 0, 0, 0, 0, 16'd0, 16'd0, 1, 1, 0, 0, "m1_d");
    vec(0, 0, 0, 1, 0, 0, 16'd0, 16'd0, 0, 1, 0, 0, "m1_stop");

    // modulus 0 on the 4-bit instance: period 16
    do_reset(1);
    vec(0, 1, 1, 0, 0, 1, 16'd0, 16'd0, 0, 0, 0, 1, "m0_start");
    for (int k = 0; k < 16; k++)
      vec(0, 1, 0, 0, 0, 0, 16'd0, 16'(k), k == 15, 1, 0, 1, "m0_run");
    vec(0, 1, 0, 0, 0, 0, 16'd0, 16'd0, 0, 1, 0, 1, "m0_wrap");
    vec(0, 0, 0, 1, 0, 0, 16'd0, 16'd1, 0, 1, 0, 1, "m0_stop");
`endif

    repeat (3) @(posedge clk);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending entries, want 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mode_timer.md
Name: mode_timer

Overview:
- Programmable modulo timer with run control and two modes: periodic (auto-reload) and one-shot.
- Advances on qualified `increment` pulses. Asserts `rolling_over` on the terminal tick. Reports running/done status.
- Successor to the fixed-modulo timer used by the button/debounce controllers. Modulus is runtime-configurable, with start/stop control.

Parameters:
- BIT_WIDTH, 16, width of `count` and of the modulus register.
- MOD_DEFAULT, 1000, modulus loaded on reset; must fit in BIT_WIDTH.
- PRESCALE, 4, increment divider, used only when TIMER_PRESCALE_EN is defined; must be >= 1.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- increment  in  1  tick qualifier; one advance per cycle where it is high.
- start  in  1  pulse; begin a run from IDLE or DONE.
- stop  in  1  pulse; abort or pause a run and return to IDLE.
- mode  in  1  0 = periodic, 1 = one-shot; sampled on the start cycle.
- cfg_wr  in  1  write `cfg_mod` into the modulus register.
- cfg_mod  in  BIT_WIDTH  new modulus value.
- count  out  BIT_WIDTH  current count, registered.
- rolling_over  out  1  combinational terminal-tick strobe.
- running  out  1  high in RUN, registered.
- done  out  1  high in DONE, registered.

Behaviour:
- Reset (asynchronous, immediate):
  - state = IDLE; count = 0; modulus = MOD_DEFAULT; latched mode = 0.
  - running = 0; done = 0; prescaler = 0.
- States:
  - IDLE: count holds its value.
  - RUN: count advances on each advance event.
  - DONE: one-shot completed; count = 0.
- Control priority, highest first: reset, stop, start, increment.
- stop in any state:
  - Next state = IDLE. count holds (pause semantics). No advance that cycle.
  - rolling_over = 0 that cycle, even at the terminal count.
- start in IDLE or DONE (no stop):
  - Next state = RUN. count <= 0. prescaler <= 0. Latch `mode`.
  - `increment` in the same cycle is ignored.
- start while in RUN: ignored. No restart, no mode change.
- Terminal value: T = modulus - 1, computed in BIT_WIDTH bits.
  - modulus = 0 gives T = all-ones, i.e. period 2^BIT_WIDTH.
- Advance event = state RUN and increment high and stop low (and prescaler at terminal, if the optional feature is enabled).
- On an advance event with count != T: count <= count + 1.
- On an advance event with count == T:
  - rolling_over = 1 combinationally in that same cycle; count <= 0.
  - Periodic: stay in RUN.
  - One-shot: next state = DONE; running falls and done rises on the next edge.
- rolling_over is 0 in IDLE and DONE regardless of `increment`.
- Latency:
  - rolling_over is coincident with the terminal-tick input.
  - running/done change one cycle after the causing event.
- cfg_wr:
  - Accepted only when state != RUN; ignored in RUN. The modulus never changes mid-run.
  - A write in the same cycle as start takes effect: the new modulus applies to the run being started.
- A paused count above a new modulus is harmless, because start always clears count.
- Periodic with modulus = 1: rolling_over = increment on every RUN cycle; count stays 0.

Optional Feature:
- Macro: TIMER_PRESCALE_EN.
- Defined:
  - A $clog2(PRESCALE)-bit prescaler counts increments in RUN and wraps at PRESCALE-1.
  - An advance event additionally requires prescaler == PRESCALE-1.
  - Prescaler cleared by reset and start; holds in IDLE and DONE.
- Undefined:
  - No prescaler logic; every qualified increment advances; PRESCALE is ignored.

Test Plan:
- Reset/defaults: assert reset mid-run with count = 37 -> count = 0, running = 0, done = 0 immediately (before the next edge); modulus reads back as 1000 via a periodic run.
- Periodic: cfg_mod = 5, start with mode = 0, increment held high 12 cycles -> count 0,1,2,3,4,0,1,2,3,4,0,1; rolling_over high on input cycles 5 and 10; running stays 1.
- One-shot: cfg_mod = 3, mode = 1, start, increment every cycle -> rolling_over on the 3rd tick; done = 1 the next cycle; further increments leave count = 0 and rolling_over = 0.
- Stop/priority: periodic run at count = 4 of modulus 5; assert stop and increment together -> rolling_over = 0, count stays 4, state IDLE; then start -> count = 0; cfg_wr during RUN with value 9 -> modulus unchanged.
- Edge moduli:
  - modulus = 1 -> rolling_over on every increment.
  - modulus = 0 with BIT_WIDTH = 4 -> rollover after 16 increments.
- TIMER_PRESCALE_EN with PRESCALE = 4, cfg_mod = 2, periodic -> count advances every 4th increment; rolling_over on increment #8 and #16.
